// File: rtl/line_buffer_taps.sv
// Line buffer that emits a vertically aligned column of N_TAPS pixels per accepted input pixel.
// Define LINE_BUFFER_TAPS_REPLICATE_EN to replicate the topmost filled row into unfilled taps instead of zeroing them.
module line_buffer_taps #(
    parameter int DATA_W   = 27,
    parameter int N_TAPS   = 3,
    parameter int MAX_LINE = 1024,
    parameter int LEN_W    = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LEN_W-1:0]         line_len,
    input  logic                     sof,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    output logic [N_TAPS*DATA_W-1:0] out_taps,
    output logic [LEN_W-1:0]         out_col,
    output logic                     out_rows_ok
);

    localparam int ADDR_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ROW_W  = $clog2(N_TAPS);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);
    localparam logic [ROW_W-1:0] TOP_ROW = ROW_W'(N_TAPS - 1);

    logic [LEN_W-1:0]  col, len_q;
    logic [ROW_W-1:0]  rows;
    logic              accept_sof;
    logic [LEN_W-1:0]  sof_len, cur_col, cur_len, next_col;
    logic [ROW_W-1:0]  cur_rows, next_rows;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] top_row;
    logic [N_TAPS*DATA_W-1:0] taps_d;

    logic [DATA_W-1:0] mem [N_TAPS-1][DEPTH];
    logic [DATA_W-1:0] rd  [N_TAPS-1];

    assign accept_sof = in_valid & sof;

    // An accepted sof pixel is processed as row 0, column 0 with the newly sampled length.
    always_comb begin
        sof_len   = (line_len == '0 || line_len > MAX_LEN) ? MAX_LEN : line_len;
        cur_col   = accept_sof ? '0 : col;
        cur_rows  = accept_sof ? '0 : rows;
        cur_len   = accept_sof ? sof_len : len_q;
        addr      = cur_col[ADDR_W-1:0];
        next_col  = cur_col + LEN_W'(1);
        next_rows = cur_rows;
        if (cur_col == cur_len - LEN_W'(1)) begin
            next_col = '0;
            if (cur_rows != TOP_ROW) begin
                next_rows = cur_rows + ROW_W'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TAPS - 1; k++) begin
            rd[k] = mem[k][addr];
        end
    end

    // Taps above the rows filled so far in this frame never expose stale memory contents.
    always_comb begin
        top_row = in_data;
        for (int j = 0; j < N_TAPS - 1; j++) begin
            if (ROW_W'(j + 1) == cur_rows) begin
                top_row = rd[j];
            end
        end
        taps_d = '0;
        taps_d[DATA_W-1:0] = in_data;
        for (int k = 1; k < N_TAPS; k++) begin
            if (ROW_W'(k) <= cur_rows) begin
                taps_d[k*DATA_W +: DATA_W] = rd[k-1];
            end else begin
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
                taps_d[k*DATA_W +: DATA_W] = top_row;
`else
                taps_d[k*DATA_W +: DATA_W] = '0;
`endif
            end
        end
    end

    // Read-before-write shift-down: each line memory takes the old value of the line below it.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[0][addr] <= in_data;
            for (int k = 1; k < N_TAPS - 1; k++) begin
                mem[k][addr] <= rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            rows        <= '0;
            len_q       <= MAX_LEN;
            out_valid   <= 1'b0;
            out_taps    <= '0;
            out_col     <= '0;
            out_rows_ok <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                col         <= next_col;
                rows        <= next_rows;
                len_q       <= cur_len;
                out_taps    <= taps_d;
                out_col     <= cur_col;
                out_rows_ok <= (cur_rows == TOP_ROW);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Self-checking bench for line_buffer_taps against a frame-image reference model.
// Define LINE_BUFFER_TAPS_REPLICATE_EN to check the replicate build.
module tb_line_buffer_taps;

    localparam int DW = 8;
    localparam int NT = 3;
    localparam int ML = 16;
    localparam int LW = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [LW-1:0]    line_len = '0;
    logic             sof = 1'b0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             out_valid;
    logic [NT*DW-1:0] out_taps;
    logic [LW-1:0]    out_col;
    logic             out_rows_ok;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: the current frame as a row/column image.
    int m_row, m_col, m_len;
    int img[int];
    logic [NT*DW-1:0] e_taps;
    logic [LW-1:0]    e_col;
    logic             e_ok;

    line_buffer_taps #(.DATA_W(DW), .N_TAPS(NT), .MAX_LINE(ML), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .line_len(line_len), .sof(sof), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_taps(out_taps), .out_col(out_col),
        .out_rows_ok(out_rows_ok)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_row = 0; m_col = 0; m_len = ML;
        img.delete();
        e_taps = '0; e_col = '0; e_ok = 1'b0;
    endtask

    task automatic model_step(input bit s, input logic [DW-1:0] d, input logic [LW-1:0] ll);
        int rsat;
        logic [DW-1:0] top, val;
        if (s) begin
            m_row = 0; m_col = 0;
            m_len = (ll == 0 || int'(ll) > ML) ? ML : int'(ll);
            img.delete();
        end
        rsat = (m_row > NT - 1) ? NT - 1 : m_row;
        top = (rsat == 0) ? d : DW'(img[(m_row - rsat) * 64 + m_col]);
        e_taps = '0;
        for (int k = 0; k < NT; k++) begin
            if (k == 0) val = d;
            else if (k <= rsat) val = DW'(img[(m_row - k) * 64 + m_col]);
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
            else val = top;
`else
            else val = '0;
`endif
            e_taps[k*DW +: DW] = val;
        end
        e_col = LW'(m_col);
        e_ok = (m_row >= NT - 1);
        img[m_row * 64 + m_col] = int'(d);
        m_col++;
        if (m_col == m_len) begin
            m_col = 0;
            m_row++;
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [DW-1:0] d, input logic [LW-1:0] ll);
        in_valid = v; sof = s; in_data = d; line_len = ll;
        if (v) model_step(s, d, ll);
        @(posedge clk);
        #1;
        in_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({out_valid, out_taps, out_col, out_rows_ok} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got v=%b taps=%h col=%0d ok=%b, want all 0",
                     out_valid, out_taps, out_col, out_rows_ok);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_taps, out_col, out_rows_ok} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got v=%b taps=%h col=%0d ok=%b, want all 0",
                     out_valid, out_taps, out_col, out_rows_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [NT*DW-1:0] p5;
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
        p5 = 24'h010105;
`else
        p5 = 24'h000105;
`endif
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, i == 1, DW'(i), 5'd4);
            n_checks++;
            if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, e_taps, e_col, e_ok}) begin
                n_fail++;
                $display("[TB] FAIL fill pix %0d: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=%0d ok=%b",
                         i, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
            end
            if (i == 5) begin
                n_checks++;
                if ({out_taps, out_rows_ok} !== {p5, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL fill_pix5: got taps=%h ok=%b, want taps=%h ok=0", out_taps, out_rows_ok, p5);
                end
            end
            if (i == 9) begin
                n_checks++;
                if ({out_taps, out_rows_ok, out_col} !== {24'h010509, 1'b1, 5'd0}) begin
                    n_fail++;
                    $display("[TB] FAIL fill_pix9: got taps=%h ok=%b col=%0d, want taps=010509 ok=1 col=0",
                             out_taps, out_rows_ok, out_col);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [NT*DW-1:0] p7;
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
        p7 = 24'h030307;
`else
        p7 = 24'h000307;
`endif
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, i == 1, DW'(i), 5'd4);
            n_checks++;
            if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, e_taps, e_col, e_ok}) begin
                n_fail++;
                $display("[TB] FAIL stall pix %0d: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=%0d ok=%b",
                         i, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
            end
            if (i == 7) begin
                n_checks++;
                if (out_taps !== p7) begin
                    n_fail++;
                    $display("[TB] FAIL stall_pix7: got taps=%h, want taps=%h", out_taps, p7);
                end
            end
            if (i == 6) begin
                for (int j = 0; j < 3; j++) begin
                    drive(1'b0, 1'b1, DW'($urandom), LW'($urandom));
                    n_checks++;
                    if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b0, e_taps, e_col, e_ok}) begin
                        n_fail++;
                        $display("[TB] FAIL stall_hold %0d: got v=%b taps=%h col=%0d ok=%b, want v=0 taps=%h col=%0d ok=%b",
                                 j, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
                    end
                end
            end
        end
    endtask

    task automatic test_new_frame();
        logic [NT*DW-1:0] p50;
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
        p50 = 24'h323232;
`else
        p50 = 24'h000032;
`endif
        drive(1'b1, 1'b1, 8'd50, 5'd2);
        n_checks++;
        if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, p50, 5'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL new_frame_first: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=0 ok=0",
                     out_valid, out_taps, out_col, out_rows_ok, p50);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, DW'($urandom), LW'($urandom));
            n_checks++;
            if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, e_taps, e_col, e_ok}) begin
                n_fail++;
                $display("[TB] FAIL new_frame pix %0d: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=%0d ok=%b",
                         i, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
            end
        end
    endtask

    task automatic test_len_clamp();
        logic [LW-1:0] lens [2];
        lens[0] = 5'd0;
        lens[1] = 5'd20;
        for (int l = 0; l < 2; l++) begin
            for (int i = 1; i <= 18; i++) begin
                drive(1'b1, i == 1, DW'(i), lens[l]);
                n_checks++;
                if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, e_taps, e_col, e_ok}) begin
                    n_fail++;
                    $display("[TB] FAIL clamp len=%0d pix %0d: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=%0d ok=%b",
                             lens[l], i, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
                end
                if (i == 17) begin
                    n_checks++;
                    if ({out_taps[2*DW-1:DW], out_col} !== {8'd1, 5'd0}) begin
                        n_fail++;
                        $display("[TB] FAIL clamp_pix17 len=%0d: got slice1=%0d col=%0d, want slice1=1 col=0",
                                 lens[l], out_taps[2*DW-1:DW], out_col);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [NT*DW-1:0] first;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i == 1, DW'(i + 100), 5'd4);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_taps, out_col, out_rows_ok} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midline_reset: got v=%b taps=%h col=%0d ok=%b, want all 0",
                     out_valid, out_taps, out_col, out_rows_ok);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef LINE_BUFFER_TAPS_REPLICATE_EN
        first = 24'h636363;
`else
        first = 24'h000063;
`endif
        drive(1'b1, 1'b0, 8'd99, 5'd3);
        n_checks++;
        if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, first, 5'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL post_reset_first: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=0 ok=0",
                     out_valid, out_taps, out_col, out_rows_ok, first);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, DW'($urandom), LW'($urandom));
            n_checks++;
            if ({out_valid, out_taps, out_col, out_rows_ok} !== {1'b1, e_taps, e_col, e_ok}) begin
                n_fail++;
                $display("[TB] FAIL post_reset pix %0d: got v=%b taps=%h col=%0d ok=%b, want v=1 taps=%h col=%0d ok=%b",
                         i, out_valid, out_taps, out_col, out_rows_ok, e_taps, e_col, e_ok);
            end
        end
    endtask

    task automatic test_random();
        bit v, s;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 24) == 0);
            drive(v, s, DW'($urandom), LW'($urandom_range(0, 31)));
            n_checks++;
            if ({out_valid, out_taps, out_col, out_rows_ok} !== {v, e_taps, e_col, e_ok}) begin
                n_fail++;
                $display("[TB] FAIL random %0d (valid=%b sof=%b): got v=%b taps=%h col=%0d ok=%b, want v=%b taps=%h col=%0d ok=%b",
                         n, v, s, out_valid, out_taps, out_col, out_rows_ok, v, e_taps, e_col, e_ok);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_stall();
        test_new_frame();
        test_len_clamp();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
